// File: rtl/router_pkt_tx.sv
// router_pkt_tx: packet source for the router input port.
// Buffers payload bytes, then sends header, payload and parity.
module router_pkt_tx #(
    parameter int MAX_LEN = 63
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       ready,
    output logic       done,
    output logic       err,
    output logic [5:0] count
);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] count_q, count_d;
    logic [5:0] len_q, len_d;
    logic [5:0] ptr_q, ptr_d;
    logic [7:0] parity_q, parity_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic       wr_fire;
    logic [7:0] mem_q [64];

    // Next-state, buffer-write and byte-sequencing logic
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        len_d    = len_q;
        ptr_d    = ptr_q;
        parity_d = parity_q;
        data_d   = data_q;
        valid_d  = valid_q;
        err_d    = 1'b0;
        wr_fire  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (count_q == 6'd0 || dest_addr == 2'd3) begin
                        err_d = 1'b1;
                    end else begin
                        len_d    = count_q;
                        data_d   = {count_q, dest_addr};
                        parity_d = {count_q, dest_addr};
                        valid_d  = 1'b1;
                        ptr_d    = 6'd0;
                        state_d  = HEADER;
                    end
                end else if (wr_en && count_q < 6'(MAX_LEN)) begin
                    wr_fire = 1'b1;
                    count_d = count_q + 6'd1;
                end
            end
            HEADER: begin
                if (!busy) begin
                    data_d   = mem_q[0];
                    parity_d = parity_q ^ mem_q[0];
                    ptr_d    = 6'd1;
                    state_d  = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!busy) begin
                    if (ptr_q < len_q) begin
                        data_d   = mem_q[ptr_q];
                        parity_d = parity_q ^ mem_q[ptr_q];
                        ptr_d    = ptr_q + 6'd1;
                    end else begin
                        data_d  = parity_q;
                        valid_d = 1'b0;
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (!busy) begin
                    data_d  = 8'h00;
                    count_d = 6'd0;
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and bus registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= 6'd0;
            len_q    <= 6'd0;
            ptr_q    <= 6'd0;
            parity_q <= 8'h00;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            len_q    <= len_d;
            ptr_q    <= ptr_d;
            parity_q <= parity_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    // Payload storage; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[count_q] <= wr_data;
        end
    end

    assign pkt_valid = valid_q;
    assign data_out  = data_q;
    assign ready     = (state_q == IDLE);
    assign done      = (state_q == GAP);
    assign err       = err_q;
    assign count     = count_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: directed table plus hand sequences
// for the router packet source.
module tb_router_pkt_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       start;
    logic [1:0] dest_addr;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       ready;
    logic       done;
    logic       err;
    logic [5:0] count;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       st;
        logic [1:0] da;
        logic       bz;
        logic       pv;
        logic [7:0] d;
        logic       rdy;
        logic       dn;
        logic       er;
        logic [5:0] cnt;
    } vec_t;

    vec_t vecs[$];

    router_pkt_tx dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .start     (start),
        .dest_addr (dest_addr),
        .busy      (busy),
        .pkt_valid (pkt_valid),
        .data_out  (data_out),
        .ready     (ready),
        .done      (done),
        .err       (err),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] outs();
        return {pkt_valid, data_out, ready, done, err, count};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic we, input logic [7:0] wd,
                         input logic st, input logic [1:0] da,
                         input logic bz);
        wr_en = we;
        wr_data = wd;
        start = st;
        dest_addr = da;
        busy = bz;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic we, input logic [7:0] wd,
                       input logic st, input logic [1:0] da,
                       input logic bz, input logic pv,
                       input logic [7:0] d, input logic rdy,
                       input logic dn, input logic er,
                       input logic [5:0] cnt);
        vec_t v;
        v.we = we; v.wd = wd; v.st = st; v.da = da; v.bz = bz;
        v.pv = pv; v.d = d; v.rdy = rdy; v.dn = dn; v.er = er;
        v.cnt = cnt;
        vecs.push_back(v);
    endtask

    initial begin
        // basic packet: 11 22 33 to port 2
        add(1, 8'h11, 0, 0, 0, 0, 8'h00, 1, 0, 0, 1);
        add(1, 8'h22, 0, 0, 0, 0, 8'h00, 1, 0, 0, 2);
        add(1, 8'h33, 0, 0, 0, 0, 8'h00, 1, 0, 0, 3);
        add(0, 8'h00, 1, 2, 0, 1, 8'h0E, 0, 0, 0, 3);
        add(0, 8'h00, 0, 0, 0, 1, 8'h11, 0, 0, 0, 3);
        add(0, 8'h00, 0, 0, 0, 1, 8'h22, 0, 0, 0, 3);
        add(0, 8'h00, 0, 0, 0, 1, 8'h33, 0, 0, 0, 3);
        add(0, 8'h00, 0, 0, 0, 0, 8'h0E, 0, 0, 0, 3);
        add(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0);
        // back-pressure while 0x22 is on the bus
        add(1, 8'h11, 0, 0, 0, 0, 8'h00, 1, 0, 0, 1);
        add(1, 8'h22, 0, 0, 0, 0, 8'h00, 1, 0, 0, 2);
        add(1, 8'h33, 0, 0, 0, 0, 8'h00, 1, 0, 0, 3);
        add(0, 8'h00, 1, 2, 0, 1, 8'h0E, 0, 0, 0, 3);
        add(0, 8'h00, 0, 0, 0, 1, 8'h11, 0, 0, 0, 3);
        add(0, 8'h00, 0, 0, 0, 1, 8'h22, 0, 0, 0, 3);
        add(0, 8'h00, 0, 0, 1, 1, 8'h22, 0, 0, 0, 3);
        add(0, 8'h00, 0, 0, 1, 1, 8'h22, 0, 0, 0, 3);
        add(0, 8'h00, 0, 0, 0, 1, 8'h33, 0, 0, 0, 3);
        add(0, 8'h00, 0, 0, 0, 0, 8'h0E, 0, 0, 0, 3);
        add(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0);
        // rejects: empty buffer, then port 3
        add(0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0, 1, 0);
        add(0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0);
        add(1, 8'h77, 0, 0, 0, 0, 8'h00, 1, 0, 0, 1);
        add(0, 8'h00, 1, 3, 0, 0, 8'h00, 1, 0, 1, 1);
        add(0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 0, 1);
        // start with a write in the same cycle: write dropped
        add(1, 8'h99, 1, 0, 0, 1, 8'h04, 0, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 1, 8'h77, 0, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 0, 8'h73, 0, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0);
        // writes ignored during HEADER and PAYLOAD
        add(1, 8'hA0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 1);
        add(1, 8'hA1, 0, 0, 0, 0, 8'h00, 1, 0, 0, 2);
        add(0, 8'h00, 1, 1, 0, 1, 8'h09, 0, 0, 0, 2);
        add(1, 8'hFF, 0, 0, 0, 1, 8'hA0, 0, 0, 0, 2);
        add(1, 8'hEE, 0, 0, 0, 1, 8'hA1, 0, 0, 0, 2);
        add(0, 8'h00, 0, 0, 0, 0, 8'h08, 0, 0, 0, 2);
        add(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0);

        reset = 1'b1;
        drive(0, 8'h00, 0, 0, 0);
        #12;
        chk("reset_state", 32'(outs()), 32'({1'b0, 8'h00, 1'b1,
            1'b0, 1'b0, 6'd0}));
        step();
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].we, vecs[i].wd, vecs[i].st, vecs[i].da,
                  vecs[i].bz);
            step();
            chk($sformatf("vec%0d", i), 32'(outs()),
                32'({vecs[i].pv, vecs[i].d, vecs[i].rdy, vecs[i].dn,
                     vecs[i].er, vecs[i].cnt}));
        end

        // full buffer: 70 writes saturate at 63
        for (int i = 1; i <= 70; i++) begin
            drive(1, 8'(i), 0, 0, 0);
            step();
            chk($sformatf("fill%0d", i), 32'(count),
                32'((i > 63) ? 63 : i));
        end
        drive(0, 8'h00, 1, 1, 0);
        step();
        chk("full_hdr", 32'({pkt_valid, data_out}), 32'({1'b1, 8'hFD}));
        drive(0, 8'h00, 0, 0, 0);
        for (int i = 1; i <= 63; i++) begin
            step();
            chk($sformatf("full_pl%0d", i), 32'({pkt_valid, data_out}),
                32'({1'b1, 8'(i)}));
        end
        step();
        chk("full_par", 32'({pkt_valid, data_out}), 32'({1'b0, 8'hFD}));
        step();
        chk("full_done", 32'({done, count}), 32'({1'b1, 6'd0}));
        step();
        chk("full_ready", 32'({ready, done}), 32'({1'b1, 1'b0}));

        // reset during the 2nd payload byte
        drive(1, 8'h10, 0, 0, 0); step();
        drive(1, 8'h20, 0, 0, 0); step();
        drive(1, 8'h30, 0, 0, 0); step();
        drive(0, 8'h00, 1, 0, 0); step();
        chk("rst_hdr", 32'({pkt_valid, data_out}), 32'({1'b1, 8'h0C}));
        drive(0, 8'h00, 0, 0, 0);
        step();
        step();
        chk("rst_pl2", 32'({pkt_valid, data_out}), 32'({1'b1, 8'h20}));
        #2 reset = 1'b1;
        #1;
        chk("rst_async", 32'(outs()), 32'({1'b0, 8'h00, 1'b1,
            1'b0, 1'b0, 6'd0}));
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst_quiet%0d", i),
                32'({pkt_valid, done, ready, count}),
                32'({1'b0, 1'b0, 1'b1, 6'd0}));
        end
        drive(1, 8'h5A, 0, 0, 0); step();
        drive(0, 8'h00, 1, 0, 0); step();
        chk("new_hdr", 32'({pkt_valid, data_out}), 32'({1'b1, 8'h04}));
        drive(0, 8'h00, 0, 0, 0);
        step();
        chk("new_pl", 32'({pkt_valid, data_out}), 32'({1'b1, 8'h5A}));
        step();
        chk("new_par", 32'({pkt_valid, data_out}), 32'({1'b0, 8'h5E}));
        step();
        chk("new_done", 32'({done, count}), 32'({1'b1, 6'd0}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet source for the router 1x3 input port. It buffers up to 63 payload bytes written by a host. On `start` it emits one packet into the router's packet interface: a header byte, the payload bytes, then an even-XOR parity byte. It drives `pkt_valid` and `data_out` and honours the router's `busy` back-pressure. It is the transmitting end of the same header/payload/parity protocol the router register block receives and checks.

## Interface
- `MAX_LEN`, 63: payload buffer depth in bytes; fixed by the 6-bit length field.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `wr_en` in 1: write one payload byte into the buffer; honoured only in IDLE.
- `wr_data` in 8: payload byte to write.
- `start` in 1: request transmission; honoured only in IDLE.
- `dest_addr` in 2: destination port 0..2, sampled with `start`.
- `busy` in 1: router not accepting; the current byte is held.
- `pkt_valid` out 1: high while header/payload are presented; low during parity.
- `data_out` out 8: registered byte on the router data bus.
- `ready` out 1: high in IDLE.
- `done` out 1: one-cycle pulse after the parity byte is accepted.
- `err` out 1: one-cycle pulse when a `start` is rejected.
- `count` out 6: payload bytes currently buffered.

## Operation
- **Buffer**
  - 64x8 register array with a write pointer (equal to `count`) and a read pointer.
  - A write in IDLE with `count < 63` stores `wr_data` at index `count` and increments `count`.
  - Writes at `count == 63`, or outside IDLE, are ignored.
- **States:** IDLE, HEADER, PAYLOAD, PARITY, GAP.
- **IDLE**
  - Outputs: `pkt_valid=0`, `data_out=0`, `ready=1`.
  - On `start`: if `count==0` or `dest_addr==3`, pulse `err` and stay in IDLE; `count` is unchanged.
  - Otherwise latch `len=count` and go to HEADER, with `data_out={len,dest_addr}`, `pkt_valid=1`, `parity={len,dest_addr}`, read pointer 0.
  - If `start` and `wr_en` occur in the same cycle, the write is dropped.
- **Byte transfer rule:** a byte transfers on a rising edge where the state is HEADER, PAYLOAD or PARITY and `busy=0`. While `busy=1`, `data_out` and `pkt_valid` hold unchanged.
- **HEADER:** on transfer, load `buf[0]` into `data_out`, XOR it into `parity`, read pointer becomes 1, go to PAYLOAD.
- **PAYLOAD:** on transfer:
  - If read pointer < `len`: load `buf[ptr]`, XOR it into `parity`, increment the pointer.
  - Else (last payload byte accepted): load `data_out=parity`, `pkt_valid=0`, go to PARITY.
- **PARITY:** on transfer, `data_out=0`, `count=0` (buffer consumed), go to GAP.
- **GAP:** one cycle with `pkt_valid=0` and `done=1`, then IDLE. This gives the router one idle cycle between packets.
- **Parity value:** XOR of the header and all payload bytes. The parity byte itself is not included.
- **Reset** (any time, including mid-packet):
  - State goes to IDLE.
  - `pkt_valid=0`, `data_out=0`, `done=0`, `err=0`, `count=0`, pointers 0, `parity=0`.
  - Buffer contents are don't-care.
  - No partial packet resumes.

## Timing
- **Reset values:** `pkt_valid=0`, `data_out=8'h00`, `ready=1`, `done=0`, `err=0`, `count=0`.
- **Start to header:** the header is visible on `data_out` one cycle after the edge that samples `start`.
- **With `busy` held low:** `len+2` consecutive byte cycles (header, `len` payload, parity), then one GAP cycle. `ready` returns `len+3` cycles after the header first appears.
- **Bus timing:** `pkt_valid` falls on the same edge that places parity on `data_out`. No bubbles with `pkt_valid=1` between header and last payload byte.
- **`err`:** asserted in the cycle after the rejected `start`.
- **`done`:** asserted in the cycle after the parity transfer edge.
- **`count`:** updates one cycle after `wr_en`.

## Test plan
- **Basic packet:** write 0x11, 0x22, 0x33; `start` with `dest_addr=2`, `busy=0`.
  - Required bus sequence: 0x0E, 0x11, 0x22, 0x33 with `pkt_valid=1`.
  - Then 0x0E with `pkt_valid=0`.
  - `done` pulses once; `count` returns to 0.
- **Back-pressure:** same packet, `busy=1` for 2 cycles while 0x22 is presented.
  - 0x22 and `pkt_valid=1` hold for 3 cycles; parity is still 0x0E.
- **Rejects:**
  - `start` with `count=0` -> `err` pulse, `ready` stays 1, `pkt_valid` stays 0.
  - `start` with `dest_addr=3` after 1 write -> `err` pulse, `count` stays 1.
- **Full buffer:** 70 writes of 0x01..0x46.
  - `count` saturates at 63.
  - `start` with `dest_addr=1` -> header 0xFD, payload 0x01..0x3F, parity = 0xFD XOR all 63 bytes.
- **Writes ignored:** `wr_en` asserted during PAYLOAD -> `count` unchanged, payload unaffected.
- **Reset mid-packet:** assert `reset` during the 2nd payload byte.
  - `pkt_valid=0` and `data_out=0` immediately (asynchronous).
  - `count=0`, no `done`.
  - A new 1-byte packet afterwards (byte 0x5A, `dest_addr=0`) transmits correctly: 0x04, 0x5A, parity 0x5E.
